// File: rtl/mem_debug_dumper.sv
// Walks data memory through the debug read port and streams each word
// as NB_BYTE-wide bytes, most-significant byte first, on a valid/ready link.
module mem_debug_dumper #(
  parameter int NB_DEPTH     = 10,
  parameter int RAM_WIDTH    = 32,
  parameter int NB_BYTE      = 8,
  parameter int READ_LATENCY = 1,
  parameter int N_WORDS      = 2**(NB_DEPTH-2)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [NB_DEPTH-3:0]   o_addr_debug,
  output logic                  o_debug_enb,
  input  logic [RAM_WIDTH-1:0]  i_data_debug,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int AW = NB_DEPTH - 2;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(N_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        word_q, word_d;
  logic [1:0]           byte_q, byte_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic [RAM_WIDTH-1:0] shift_q, shift_d;
  logic                 xfer;

  assign xfer = (state_q == SEND) && i_tx_ready;

  // State and datapath registers, cleared asynchronously so a mid-dump reset aborts at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      lat_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      lat_q   <= lat_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and datapath update: address, wait out read latency, then shift out 4 bytes
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    lat_d   = lat_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          word_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          shift_d = i_data_debug;
          byte_d  = '0;
          state_d = SEND;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      SEND: begin
        if (xfer) begin
          shift_d = {shift_q[RAM_WIDTH-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            // Terminal compare on the last word keeps the counter from ever wrapping
            if (word_q == LAST_WORD) begin
              state_d = DONE;
            end else begin
              word_d  = word_q + AW'(1);
              state_d = ADDR;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so reset forces them immediately
  always_comb begin
    o_addr_debug = word_q;
    o_debug_enb  = !((state_q == ADDR) || (state_q == WAIT) || (state_q == SEND));
    o_tx_valid   = (state_q == SEND);
    o_tx_data    = shift_q[RAM_WIDTH-1 -: NB_BYTE];
    o_busy       = (state_q != IDLE);
    o_done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Bench for mem_debug_dumper: two instances (short dump with latency 1,
// full-depth dump with latency 2) checked against scoreboard queues.
module tb_mem_debug_dumper;

  logic        clk;
  logic        rst;

  // instance A: N_WORDS=2, READ_LATENCY=1
  logic        start_a, enb_a, valid_a, ready_a, busy_a, done_a;
  logic [7:0]  addr_a;
  logic [31:0] rdata_a;
  logic [7:0]  data_a;

  // instance B: defaults, READ_LATENCY=2
  logic        start_b, enb_b, valid_b, ready_b, busy_b, done_b;
  logic [7:0]  addr_b;
  logic [31:0] rdata_b;
  logic [7:0]  data_b;
  logic [7:0]  raddr1_b;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  logic [7:0]  aq_a[$];
  logic [7:0]  aq_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  int a_tx_cnt = 0, a_done_cnt = 0;
  int b_tx_cnt = 0, b_done_cnt = 0;
  logic [7:0] a_last_addr, b_last_addr;
  logic a_prev_stall = 0, b_prev_stall = 0;
  logic [7:0] a_prev_data, b_prev_data;
  logic a_prev_enb = 1, b_prev_enb = 1;
  logic [7:0] a_prev_addr, b_prev_addr;

  mem_debug_dumper #(
    .NB_DEPTH(10), .RAM_WIDTH(32), .NB_BYTE(8), .READ_LATENCY(1), .N_WORDS(2)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .o_addr_debug(addr_a), .o_debug_enb(enb_a), .i_data_debug(rdata_a),
    .o_tx_data(data_a), .o_tx_valid(valid_a), .i_tx_ready(ready_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  mem_debug_dumper #(
    .READ_LATENCY(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .o_addr_debug(addr_b), .o_debug_enb(enb_b), .i_data_debug(rdata_b),
    .o_tx_data(data_b), .o_tx_valid(valid_b), .i_tx_ready(ready_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // synchronous memory models: one and two cycles of read latency
  always @(posedge clk) begin
    rdata_a  <= mem_a[addr_a];
    raddr1_b <= addr_b;
    rdata_b  <= mem_b[raddr1_b];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic push_a_dump();
    for (int w = 0; w < 2; w++) begin
      aq_a.push_back(8'(w));
      for (int b = 0; b < 4; b++) q_a.push_back(mem_a[w][31-8*b -: 8]);
    end
  endtask

  task automatic push_b_dump();
    for (int w = 0; w < 256; w++) begin
      aq_b.push_back(8'(w));
      for (int b = 0; b < 4; b++) q_b.push_back(mem_b[w][31-8*b -: 8]);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_enb"},   32'(enb_a),   32'd1);
    check_eq({pfx, "_valid"}, 32'(valid_a), 32'd0);
    check_eq({pfx, "_busy"},  32'(busy_a),  32'd0);
    check_eq({pfx, "_done"},  32'(done_a),  32'd0);
    check_eq({pfx, "_addr"},  32'(addr_a),  32'd0);
    check_eq({pfx, "_data"},  32'(data_a),  32'd0);
  endtask

  // monitor for instance A: stream holding, byte scoreboard, address order, done pulses
  always @(negedge clk) begin
    if (rst) begin
      a_prev_stall = 0;
      a_prev_enb   = 1;
    end else begin
      if (a_prev_stall) begin
        check_eq("a_valid_hold", 32'(valid_a), 32'd1);
        check_eq("a_data_hold", 32'(data_a), 32'(a_prev_data));
      end
      if (valid_a && ready_a) begin
        check_eq("a_byte_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) check_eq("a_byte", 32'(data_a), 32'(q_a.pop_front()));
        a_tx_cnt++;
      end
      a_prev_stall = valid_a && !ready_a;
      a_prev_data  = data_a;
      if (!enb_a && (a_prev_enb || addr_a != a_prev_addr)) begin
        check_eq("a_addr_expected", 32'(aq_a.size() != 0), 32'd1);
        if (aq_a.size() != 0) check_eq("a_addr", 32'(addr_a), 32'(aq_a.pop_front()));
        a_last_addr = addr_a;
      end
      a_prev_enb  = enb_a;
      a_prev_addr = addr_a;
      if (done_a) begin
        a_done_cnt++;
        check_eq("a_done_drained", 32'(q_a.size()), 32'd0);
        check_eq("a_done_enb", 32'(enb_a), 32'd1);
      end
    end
  end

  // monitor for instance B
  always @(negedge clk) begin
    if (rst) begin
      b_prev_stall = 0;
      b_prev_enb   = 1;
    end else begin
      if (b_prev_stall) begin
        check_eq("b_valid_hold", 32'(valid_b), 32'd1);
        check_eq("b_data_hold", 32'(data_b), 32'(b_prev_data));
      end
      if (valid_b && ready_b) begin
        check_eq("b_byte_expected", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) check_eq("b_byte", 32'(data_b), 32'(q_b.pop_front()));
        b_tx_cnt++;
      end
      b_prev_stall = valid_b && !ready_b;
      b_prev_data  = data_b;
      if (!enb_b && (b_prev_enb || addr_b != b_prev_addr)) begin
        check_eq("b_addr_expected", 32'(aq_b.size() != 0), 32'd1);
        if (aq_b.size() != 0) check_eq("b_addr", 32'(addr_b), 32'(aq_b.pop_front()));
        b_last_addr = addr_b;
      end
      b_prev_enb  = enb_b;
      b_prev_addr = addr_b;
      if (done_b) begin
        b_done_cnt++;
        check_eq("b_done_drained", 32'(q_b.size()), 32'd0);
      end
    end
  end

  initial begin
    int stall;
    int base;
    logic restarted;

    rst = 1; start_a = 0; start_b = 0; ready_a = 1; ready_b = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'hA5000000 | 32'(i);
      mem_b[i] = $urandom;
    end
    mem_a[0] = 32'h77775533;
    mem_a[1] = 32'h01020304;

    #2;
    check_reset_outputs("por");
    check_eq("por_b_enb", 32'(enb_b), 32'd1);
    check_eq("por_b_valid", 32'(valid_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // dump 1: backpressure on byte 2 of word 0, plus an ignored start while busy
    push_a_dump();
    @(posedge clk); #1 start_a = 1;
    stall = 0;
    restarted = 0;
    for (int c = 0; c < 200 && a_done_cnt == 0; c++) begin
      @(posedge clk); #1;
      if (c == 0) check_eq("a_busy_after_start", 32'(busy_a), 32'd1);
      if (a_tx_cnt == 2 && stall < 5) begin
        ready_a = 0;
        stall++;
      end else begin
        ready_a = 1;
      end
      if (a_tx_cnt == 5 && !restarted) begin
        start_a = 1;
        restarted = 1;
      end else begin
        start_a = 0;
      end
    end
    ready_a = 1;
    start_a = 0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("a_dump1_done_cnt", 32'(a_done_cnt), 32'd1);
    check_eq("a_dump1_bytes", 32'(a_tx_cnt), 32'd8);
    check_eq("a_dump1_stalled", 32'(stall), 32'd5);
    check_eq("a_dump1_addr_left", 32'(aq_a.size()), 32'd0);
    check_eq("a_dump1_last_addr", 32'(a_last_addr), 32'd1);
    check_eq("a_idle_busy", 32'(busy_a), 32'd0);
    check_eq("a_idle_enb", 32'(enb_a), 32'd1);

    // dump 2: aborted by a mid-clock reset after three bytes
    base = a_tx_cnt;
    push_a_dump();
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int c = 0; c < 100 && a_tx_cnt < base + 3; c++) begin
      @(posedge clk); #1;
    end
    check_eq("a_dump2_three_bytes", 32'(a_tx_cnt), 32'(base + 3));
    #3 rst = 1;
    #1;
    check_reset_outputs("midrst");
    q_a.delete();
    aq_a.delete();
    @(posedge clk); #1 rst = 0;
    check_eq("a_no_done_on_abort", 32'(a_done_cnt), 32'd1);

    // dump 3: restart from word 0 after the abort
    base = a_tx_cnt;
    push_a_dump();
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int c = 0; c < 200 && a_done_cnt < 2; c++) begin
      @(posedge clk); #1;
    end
    check_eq("a_dump3_done_cnt", 32'(a_done_cnt), 32'd2);
    check_eq("a_dump3_bytes", 32'(a_tx_cnt), 32'(base + 8));
    check_eq("a_dump3_addr_left", 32'(aq_a.size()), 32'd0);

    // full-depth dump, latency 2, random backpressure
    push_b_dump();
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int c = 0; c < 30000 && b_done_cnt == 0; c++) begin
      @(posedge clk); #1;
      ready_b = 1'($urandom_range(0, 1));
    end
    ready_b = 1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("b_done_cnt", 32'(b_done_cnt), 32'd1);
    check_eq("b_bytes", 32'(b_tx_cnt), 32'd1024);
    check_eq("b_bytes_left", 32'(q_b.size()), 32'd0);
    check_eq("b_addr_left", 32'(aq_b.size()), 32'd0);
    check_eq("b_last_addr", 32'(b_last_addr), 32'd255);
    check_eq("b_idle_enb", 32'(enb_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
